fpm_seq_ctrl: RTL
=================

FPM_SEQ_CTRL -- requirements
Module: fpm_seq_ctrl

Interface
REQ-001 Parameter: N, 32, operand/result width in bits (IEEE-754 single when 32).
REQ-002 Parameter: CNT_W, 16, width of the operation and overflow counters.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  operand pair offered.
REQ-006 Port: in_ready  output  1  controller accepts operand pair this cycle.
REQ-007 Port: in_a, in_b  input  N each  operands, signed vector.
REQ-008 Port: mul_enable  output  1  enable to the two-cycle multiplier.
REQ-009 Port: mul_a, mul_b  output  N each  operands driven to the multiplier.
REQ-010 Port: mul_result  input  N  multiplier result register.
REQ-011 Port: mul_overflow  input  1  multiplier overflow register.
REQ-012 Port: out_valid  output  1  product available.
REQ-013 Port: out_ready  input  1  consumer takes product.
REQ-014 Port: out_result, out_overflow  output  N, 1  product and overflow flag.
REQ-015 Port: op_count, ovf_count  output  CNT_W each  completed operations and completed overflowing operations.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, COMPUTE, DONE, one-hot or binary.
REQ-017 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready).
REQ-018 Accept = in_valid & in_ready; on accept, in_a/in_b SHALL be captured into operand registers driving mul_a/mul_b, and state SHALL go to LOAD.
REQ-019 mul_a/mul_b SHALL be stable from the accept edge until the next accept.
REQ-020 mul_enable SHALL be 1 exactly in LOAD and COMPUTE, 0 in IDLE and DONE.
REQ-021 LOAD SHALL go to COMPUTE unconditionally (multiplier latches operands); COMPUTE SHALL go to DONE unconditionally (multiplier latches result).
REQ-022 out_valid SHALL be 1 only in DONE; out_result=mul_result, out_overflow=mul_overflow while in DONE (multiplier holds since enable=0); both SHALL be 0 otherwise.
REQ-023 Latency: out_valid SHALL rise on the second rising edge after the accept edge.
REQ-024 DONE with out_ready=0 SHALL hold; outputs stable; in_ready=0.
REQ-025 DONE with out_ready=1 and in_valid=1 SHALL accept the new pair and go directly to LOAD (throughput one op per 3 cycles).
REQ-026 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-027 On each out handshake (out_valid & out_ready), op_count SHALL increment by 1 and ovf_count SHALL increment by 1 if out_overflow=1; both SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-028 in_valid in LOAD/COMPUTE SHALL be ignored (in_ready=0); no operand overwrite.
REQ-029 in_valid SHALL be allowed to drop without acceptance; no state change.

Reset
REQ-030 While reset=0: state=IDLE, mul_enable=0, mul_a=mul_b=0, out_valid=0, out_result=0, out_overflow=0, op_count=ovf_count=0, in_ready=0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-032 Reset asserted mid-operation (LOAD/COMPUTE/DONE) SHALL discard the operation with no counter update; stale multiplier contents SHALL never appear with out_valid=1.

Verification
REQ-033 in_a=0x40000000, in_b=0x40400000, out_ready=1 -> out_valid 2 edges after accept, out_result=0x40C00000, out_overflow=0, op_count=1.
REQ-034 in_a=0x00000000, in_b=0x3F800000 -> out_result=0x00000000, out_overflow=0.
REQ-035 in_a=in_b=0x7F000000 -> out_overflow=1, ovf_count=1; then 0x3FC00000*0x3FC00000 -> out_result=0x40100000, ovf_count stays 1.
REQ-036 out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_result constant, in_ready=0, mul_enable=0; out_ready=1 -> new accept same cycle, LOAD next.
REQ-037 reset=0 asserted in COMPUTE -> immediate IDLE, out_valid=0, counters 0; next op 0x40000000*0x40000000 -> 0x40800000.
REQ-038 CNT_W=2, 5 completed ops -> op_count=3 held.

Source files
------------

// File: rtl/fpm_seq_ctrl.sv
// fpm_seq_ctrl: sequences operand pairs through a two-cycle multiplier and hands products
// to a consumer, counting completed and overflowing operations with saturating counters.
module fpm_seq_ctrl #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             mul_enable,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [N-1:0]     mul_result,
    input  logic             mul_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic             out_overflow,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] ovf_count
);
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state;
    logic   accept;
    logic   handshake;
    // in_ready is gated by reset so nothing is offered while the block is held in reset
    assign in_ready     = reset & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept       = in_valid & in_ready;
    assign handshake    = out_valid & out_ready;
    // multiplier holds its result while enable is low, so DONE can pass it straight through
    assign out_result   = out_valid ? mul_result : '0;
    assign out_overflow = out_valid & mul_overflow;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mul_enable <= 1'b0;
            out_valid  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            op_count   <= '0;
            ovf_count  <= '0;
        end else begin
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
            if (handshake && op_count != CNT_MAX)
                op_count <= op_count + CNT_W'(1);
            if (handshake && out_overflow && ovf_count != CNT_MAX)
                ovf_count <= ovf_count + CNT_W'(1);
            case (state)
                IDLE: if (accept) begin
                    state      <= LOAD;
                    mul_enable <= 1'b1;
                end
                LOAD: state <= COMPUTE;
                COMPUTE: begin
                    state      <= DONE;
                    mul_enable <= 1'b0;
                    out_valid  <= 1'b1;
                end
                DONE: if (accept) begin
                    state      <= LOAD;
                    mul_enable <= 1'b1;
                    out_valid  <= 1'b0;
                end else if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
